ws2812b_rx_decoder: RTL and testbench
=====================================

WS2812B_RX_DECODER -- requirements
Module: ws2812b_rx_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all cycle counters and timing inputs.
REQ-002 SHALL have parameter PIXEL_BITS, default 24, bits per assembled pixel (range 1..32).
REQ-003 SHALL have parameter IDX_W, default 10, width of pixel index.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  1  asynchronous WS2812B serial line.
REQ-007 threshold_cycles  input  CNT_W  high-time above which a bit decodes as 1.
REQ-008 reset_cycles  input  CNT_W  low-time at or above which a frame-end (latch) is declared.
REQ-009 clear_err  input  1  one-cycle pulse clearing sticky error flags.
REQ-010 pixel_ready  input  1  consumer accepts pixel when high with pixel_valid.
REQ-011 pixel_valid  output  1  pixel_data/pixel_index hold a complete pixel.
REQ-012 pixel_data  output  PIXEL_BITS  assembled pixel, first received bit in MSB.
REQ-013 pixel_index  output  IDX_W  position of pixel_data within current frame, 0-based.
REQ-014 frame_end  output  1  one-cycle pulse on latch detection.
REQ-015 err_overflow  output  1  sticky: completed pixel dropped because output buffer full.
REQ-016 err_partial  output  1  sticky: frame ended with incomplete pixel.

Function
REQ-017 din SHALL pass a 2-flop synchronizer; all decoding uses synchronized value ds only.
REQ-018 FSM states SHALL be IDLE, HIGH, LOW; after reset state is IDLE.
REQ-019 IDLE: ds=1 -> HIGH with hi_cnt=1; else stay (no low counting, no frame_end).
REQ-020 HIGH: ds=1 -> hi_cnt increments, saturating at 2^CNT_W-1; ds=0 -> bit decided, LOW with lo_cnt=1.
REQ-021 Bit value SHALL be 1 iff hi_cnt > threshold_cycles (strict, unsigned); equality decodes 0.
REQ-022 Decided bit SHALL shift into shift register LSB side; bit_cnt increments.
REQ-023 When decided bit is bit PIXEL_BITS-1, pixel SHALL complete the same cycle; bit_cnt returns to 0.
REQ-024 LOW: ds=1 -> HIGH with hi_cnt=1; ds=0 -> lo_cnt increments, saturating.
REQ-025 LOW: when lo_cnt reaches reset_cycles (lo_cnt+1 == reset_cycles on the incrementing cycle) SHALL pulse frame_end one cycle, go IDLE, clear bit_cnt, shift register and frame pixel counter.
REQ-026 reset_cycles=0 or 1 SHALL behave as 1 (frame_end on first low cycle after LOW entry + 1).
REQ-027 If bit_cnt != 0 at frame_end, err_partial SHALL set; partial bits discarded.
REQ-028 Pixel completion latency: pixel_valid SHALL rise the cycle after the cycle ds is first sampled 0 ending the last bit's high pulse.
REQ-029 Completed pixel SHALL load pixel_data, pixel_index=frame pixel counter; counter then increments, wrapping at 2^IDX_W.
REQ-030 pixel_valid SHALL remain high, data/index stable, until pixel_valid & pixel_ready.
REQ-031 Completion while pixel_valid & !pixel_ready: new pixel dropped, buffer unchanged, err_overflow set; frame counter still increments.
REQ-032 Completion while pixel_valid & pixel_ready: new pixel loaded, pixel_valid stays 1, no error.
REQ-033 Handshake SHALL be independent of frame_end; a buffered pixel survives frame_end.
REQ-034 clear_err SHALL clear both sticky flags; simultaneous set event wins (flag stays 1).

Reset
REQ-035 On reset: state IDLE, counters 0, synchronizer flops 0, pixel_valid 0, pixel_data 0, pixel_index 0, frame_end 0, err_overflow 0, err_partial 0.
REQ-036 Reset mid-pixel or mid-handshake SHALL discard all partial and buffered data with no output pulse.

Verification
REQ-037 threshold=20, reset=400, 24 bits alternating 1/0 (high 32 / 16 cycles, period 60), pixel_ready=1 -> pixel_data=0xAAAAAA, pixel_index=0, pixel_valid one cycle.
REQ-038 Two pixels 0x123456, 0xABCDEF back-to-back, then low 400 -> indices 0 and 1, one frame_end, err_partial=0; next frame restarts index 0.
REQ-039 hi_cnt exactly 20 -> bit 0; 21 -> bit 1.
REQ-040 pixel_ready=0, two pixels sent -> first pixel held, err_overflow=1; clear_err -> 0; ready=1 -> first pixel accepted.
REQ-041 10 bits then low 400 -> frame_end, err_partial=1, no pixel_valid.
REQ-042 reset asserted after 12 bits -> all outputs 0; subsequent full 24-bit pixel decodes correctly with index 0.

Source files
------------

// File: rtl/ws2812b_rx_decoder.sv
// ws2812b_rx_decoder
//   Decodes a WS2812B-style single-wire stream into fixed-width pixels.
//   Each bit is a high pulse followed by a low gap. A high time longer than
//   threshold_cycles decodes as 1. A low time of reset_cycles ends the frame.
//   Completed pixels are held in a one-entry output buffer with a
//   valid/ready handshake.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   din               - asynchronous serial line (synchronized internally)
//   threshold_cycles  - high-time above which a bit is 1
//   reset_cycles      - low-time that marks a frame end (latch)
//   clear_err         - pulse that clears the sticky error flags
//   pixel_ready       - consumer accepts the buffered pixel
//   pixel_valid/data/index - buffered pixel, first bit in MSB, index in frame
//   frame_end         - one-cycle pulse on latch detection
//   err_overflow      - sticky: completed pixel dropped, buffer was full
//   err_partial       - sticky: frame ended part-way through a pixel
module ws2812b_rx_decoder #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned PIXEL_BITS = 24,
   parameter int unsigned IDX_W      = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  din,
   input  logic [CNT_W-1:0]      threshold_cycles,
   input  logic [CNT_W-1:0]      reset_cycles,
   input  logic                  clear_err,
   input  logic                  pixel_ready,
   output logic                  pixel_valid,
   output logic [PIXEL_BITS-1:0] pixel_data,
   output logic [IDX_W-1:0]      pixel_index,
   output logic                  frame_end,
   output logic                  err_overflow,
   output logic                  err_partial
);

   localparam int unsigned        BitCntW = 6;
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(PIXEL_BITS - 1);
   localparam logic [CNT_W-1:0]   CntMax  = '1;

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

   state_e                state_q, state_d;
   logic                  din_meta_q, din_meta_d;
   logic                  ds_q, ds_d;
   logic [CNT_W-1:0]      hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0]      lo_cnt_q, lo_cnt_d;
   logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [PIXEL_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]      frame_idx_q, frame_idx_d;
   logic                  pixel_valid_q, pixel_valid_d;
   logic [PIXEL_BITS-1:0] pixel_data_q, pixel_data_d;
   logic [IDX_W-1:0]      pixel_index_q, pixel_index_d;
   logic                  frame_end_q, frame_end_d;
   logic                  err_overflow_q, err_overflow_d;
   logic                  err_partial_q, err_partial_d;

   logic                  bit_val;
   logic [PIXEL_BITS-1:0] shift_in;
   logic [CNT_W:0]        lo_inc;
   logic                  lo_done;
   logic                  pix_done;
   logic                  latch_evt;

   always_comb begin
      din_meta_d     = din;
      ds_d           = din_meta_q;
      state_d        = state_q;
      hi_cnt_d       = hi_cnt_q;
      lo_cnt_d       = lo_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      frame_idx_d    = frame_idx_q;
      pixel_valid_d  = pixel_valid_q;
      pixel_data_d   = pixel_data_q;
      pixel_index_d  = pixel_index_q;
      frame_end_d    = 1'b0;
      pix_done       = 1'b0;
      latch_evt      = 1'b0;

      bit_val  = hi_cnt_q > threshold_cycles;
      shift_in = (shift_q << 1) | PIXEL_BITS'(bit_val);
      // Extra bit keeps the compare exact when lo_cnt is saturated; reset_cycles
      // of 0..2 all fire on the first low cycle spent in StLow.
      lo_inc   = {1'b0, lo_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
      lo_done  = lo_inc >= {1'b0, reset_cycles};

      unique case (state_q)
         StIdle: begin
            if (ds_q) begin
               state_d  = StHigh;
               hi_cnt_d = CNT_W'(1);
            end
         end
         StHigh: begin
            if (ds_q) begin
               if (hi_cnt_q != CntMax) hi_cnt_d = hi_cnt_q + CNT_W'(1);
            end else begin
               state_d  = StLow;
               lo_cnt_d = CNT_W'(1);
               if (bit_cnt_q == LastBit) begin
                  pix_done  = 1'b1;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + BitCntW'(1);
                  shift_d   = shift_in;
               end
            end
         end
         StLow: begin
            if (ds_q) begin
               state_d  = StHigh;
               hi_cnt_d = CNT_W'(1);
            end else if (lo_done) begin
               latch_evt   = 1'b1;
               frame_end_d = 1'b1;
               state_d     = StIdle;
               bit_cnt_d   = '0;
               shift_d     = '0;
               frame_idx_d = '0;
            end else if (lo_cnt_q != CntMax) begin
               lo_cnt_d = lo_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Output buffer: a completion is loaded if the slot is free or being
      // drained this cycle, otherwise it is dropped.
      if (pix_done) begin
         frame_idx_d = frame_idx_q + IDX_W'(1);
         if (!pixel_valid_q || pixel_ready) begin
            pixel_valid_d = 1'b1;
            pixel_data_d  = shift_in;
            pixel_index_d = frame_idx_q;
         end
      end else if (pixel_valid_q && pixel_ready) begin
         pixel_valid_d = 1'b0;
      end

      // Set events take priority over clear_err.
      err_overflow_d = clear_err ? 1'b0 : err_overflow_q;
      if (pix_done && pixel_valid_q && !pixel_ready) err_overflow_d = 1'b1;
      err_partial_d = clear_err ? 1'b0 : err_partial_q;
      if (latch_evt && (bit_cnt_q != '0)) err_partial_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         din_meta_q     <= 1'b0;
         ds_q           <= 1'b0;
         hi_cnt_q       <= '0;
         lo_cnt_q       <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         frame_idx_q    <= '0;
         pixel_valid_q  <= 1'b0;
         pixel_data_q   <= '0;
         pixel_index_q  <= '0;
         frame_end_q    <= 1'b0;
         err_overflow_q <= 1'b0;
         err_partial_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         din_meta_q     <= din_meta_d;
         ds_q           <= ds_d;
         hi_cnt_q       <= hi_cnt_d;
         lo_cnt_q       <= lo_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         frame_idx_q    <= frame_idx_d;
         pixel_valid_q  <= pixel_valid_d;
         pixel_data_q   <= pixel_data_d;
         pixel_index_q  <= pixel_index_d;
         frame_end_q    <= frame_end_d;
         err_overflow_q <= err_overflow_d;
         err_partial_q  <= err_partial_d;
      end
   end

   assign pixel_valid  = pixel_valid_q;
   assign pixel_data   = pixel_data_q;
   assign pixel_index  = pixel_index_q;
   assign frame_end    = frame_end_q;
   assign err_overflow = err_overflow_q;
   assign err_partial  = err_partial_q;

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// tb_ws2812b_rx_decoder
//   Drives pulse trains on din and compares the decoder against a reference
//   model that works on pulse lengths and bit lists rather than states.
module tb_ws2812b_rx_decoder;

   localparam int PB = 24;

   logic        clk = 1'b0;
   logic        reset;
   logic        din;
   logic [15:0] threshold_cycles;
   logic [15:0] reset_cycles;
   logic        clear_err;
   logic        pixel_ready;
   logic        pixel_valid;
   logic [23:0] pixel_data;
   logic [9:0]  pixel_index;
   logic        frame_end;
   logic        err_overflow;
   logic        err_partial;

   ws2812b_rx_decoder #(
      .CNT_W      (16),
      .PIXEL_BITS (24),
      .IDX_W      (10)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .din              (din),
      .threshold_cycles (threshold_cycles),
      .reset_cycles     (reset_cycles),
      .clear_err        (clear_err),
      .pixel_ready      (pixel_ready),
      .pixel_valid      (pixel_valid),
      .pixel_data       (pixel_data),
      .pixel_index      (pixel_index),
      .frame_end        (frame_end),
      .err_overflow     (err_overflow),
      .err_partial      (err_partial)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation side: everything sampled on the falling edge.
   logic [63:0] acc_q[$];
   int          fe_count = 0;
   int          fe_cyc   = 0;
   int          rise_cyc = 0;
   int          valid_hi = 0;
   logic        valid_prev = 1'b0;

   always @(negedge clk) begin
      if (frame_end) begin
         fe_count <= fe_count + 1;
         fe_cyc   <= cyc;
      end
      if (pixel_valid) valid_hi <= valid_hi + 1;
      if (pixel_valid && !valid_prev) rise_cyc <= cyc;
      valid_prev <= pixel_valid;
      if (pixel_valid && pixel_ready && !reset)
         acc_q.push_back({22'b0, pixel_index, 8'b0, pixel_data});
   end

   // Reference model state
   logic [63:0] exp_q[$];
   int          exp_rd = 0;
   int          acc_rd = 0;
   logic [23:0] m_cur = '0;
   int          m_nbits = 0;
   int          m_fidx = 0;
   logic        exp_partial = 1'b0;
   int          last_fall = 0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      din = v;
      repeat (n) tick();
   endtask

   function automatic int hi_for(input logic b);
      int t;
      t = int'(threshold_cycles);
      if (b) return t + 1 + int'($urandom_range(12, 0));
      return int'($urandom_range(t, 1));
   endfunction

   // One bit cell: hi samples high then lo samples low.
   task automatic send_pulse(input int hi, input int lo);
      logic [63:0] e;
      hold(1'b1, hi);
      last_fall = cyc;
      hold(1'b0, lo);
      m_cur = {m_cur[PB-2:0], (hi > int'(threshold_cycles))};
      m_nbits++;
      if (m_nbits == PB) begin
         e = {22'b0, m_fidx[9:0], 8'b0, m_cur};
         exp_q.push_back(e);
         m_fidx  = (m_fidx + 1) % 1024;
         m_nbits = 0;
      end
   endtask

   task automatic send_pixel(input logic [23:0] v);
      for (int i = PB - 1; i >= 0; i--)
         send_pulse(hi_for(v[i]), int'($urandom_range(20, 5)));
   endtask

   task automatic end_frame(input int n);
      hold(1'b0, n);
      if (m_nbits != 0) exp_partial = 1'b1;
      m_nbits = 0;
      m_cur   = '0;
      m_fidx  = 0;
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      exp_partial = 1'b0;
   endtask

   task automatic check_pixels(input string tag);
      int n_exp;
      int n_acc;
      n_exp = exp_q.size() - exp_rd;
      n_acc = acc_q.size() - acc_rd;
      check({tag, "_count"}, 64'(n_acc), 64'(n_exp));
      for (int i = 0; i < ((n_exp < n_acc) ? n_exp : n_acc); i++)
         check({tag, "_pix"}, acc_q[acc_rd + i], exp_q[exp_rd + i]);
      exp_rd = exp_q.size();
      acc_rd = acc_q.size();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(pixel_valid), 64'd0);
      check({tag, "_data"},  64'(pixel_data), 64'd0);
      check({tag, "_index"}, 64'(pixel_index), 64'd0);
      check({tag, "_fe"},    64'(frame_end), 64'd0);
      check({tag, "_ovf"},   64'(err_overflow), 64'd0);
      check({tag, "_part"},  64'(err_partial), 64'd0);
   endtask

   initial begin
      int          fe0;
      int          v0;
      int          lf;
      logic [23:0] pa;
      logic [23:0] pb;
      logic [23:0] pv;
      logic [63:0] e;

      reset            = 1'b1;
      din              = 1'b0;
      clear_err        = 1'b0;
      pixel_ready      = 1'b1;
      threshold_cycles = 16'd20;
      reset_cycles     = 16'd400;
      repeat (4) tick();
      reset = 1'b0;
      tick();
      check_all_zero("reset");

      // Alternating 1/0 pattern with exact latency and frame-end timing.
      fe0 = fe_count;
      v0  = valid_hi;
      for (int i = 0; i < PB; i++) begin
         if (i % 2 == 0) send_pulse(32, 28);
         else            send_pulse(16, 44);
      end
      lf = last_fall;
      end_frame(410);
      check("alt_latency", 64'(rise_cyc), 64'(lf + 3));
      check("alt_fe_cyc", 64'(fe_cyc), 64'(lf + 402));
      check("alt_valid_cycles", 64'(valid_hi - v0), 64'd1);
      check("alt_data", 64'(pixel_data), 64'hAAAAAA);
      check("alt_fe_count", 64'(fe_count - fe0), 64'd1);
      check_pixels("alt");

      // Two back-to-back pixels, then a fresh frame restarting at index 0.
      fe0 = fe_count;
      send_pixel(24'h123456);
      send_pixel(24'hABCDEF);
      end_frame(410);
      check("two_fe_count", 64'(fe_count - fe0), 64'd1);
      check("two_partial", 64'(err_partial), 64'd0);
      check_pixels("two");
      send_pixel(24'($urandom()));
      end_frame(410);
      check("restart_index", 64'(pixel_index), 64'd0);
      check_pixels("restart");

      // Threshold boundary: 20 high samples is 0, 21 is 1.
      pv = 24'($urandom());
      for (int i = PB - 1; i >= 0; i--) send_pulse(pv[i] ? 21 : 20, 30);
      end_frame(410);
      check("thr_data", 64'(pixel_data), 64'(pv));
      check_pixels("thr");

      // Backpressure: second pixel dropped, first held across frame end.
      pixel_ready = 1'b0;
      pa = 24'($urandom());
      pb = 24'($urandom());
      fe0 = fe_count;
      send_pixel(pa);
      send_pixel(pb);
      check("bp_valid", 64'(pixel_valid), 64'd1);
      check("bp_data", 64'(pixel_data), 64'(pa));
      check("bp_index", 64'(pixel_index), 64'd0);
      check("bp_ovf", 64'(err_overflow), 64'd1);
      end_frame(410);
      check("bp_fe_count", 64'(fe_count - fe0), 64'd1);
      check("bp_hold_valid", 64'(pixel_valid), 64'd1);
      check("bp_hold_data", 64'(pixel_data), 64'(pa));
      pulse_clear();
      check("bp_ovf_clear", 64'(err_overflow), 64'd0);
      pixel_ready = 1'b1;
      tick();
      tick();
      check("bp_valid_drop", 64'(pixel_valid), 64'd0);
      check("bp_acc_count", 64'(acc_q.size() - acc_rd), 64'd1);
      e = {22'b0, 10'd0, 8'b0, pa};
      if (acc_q.size() > acc_rd) check("bp_acc_pix", acc_q[acc_rd], e);
      acc_rd = acc_q.size();
      exp_rd = exp_q.size();

      // Partial pixel at frame end.
      fe0 = fe_count;
      v0  = valid_hi;
      for (int i = 0; i < 10; i++) send_pulse(hi_for(1'($urandom())), 10);
      end_frame(410);
      check("part_fe_count", 64'(fe_count - fe0), 64'd1);
      check("part_flag", 64'(err_partial), 64'(exp_partial));
      check("part_no_valid", 64'(valid_hi - v0), 64'd0);
      check_pixels("part");
      pulse_clear();
      check("part_clear", 64'(err_partial), 64'd0);

      // reset_cycles of 0 and 1 both latch on the second low sample.
      for (int r = 0; r < 2; r++) begin
         reset_cycles = 16'(r);
         fe0 = fe_count;
         send_pulse(5, 12);
         lf = last_fall;
         end_frame(2);
         check("rc_small_fe_cyc", 64'(fe_cyc), 64'(lf + 4));
         check("rc_small_fe_count", 64'(fe_count - fe0), 64'd1);
         check("rc_small_partial", 64'(err_partial), 64'(exp_partial));
         pulse_clear();
      end
      reset_cycles = 16'd400;

      // Reset in the middle of a pixel.
      fe0 = fe_count;
      v0  = valid_hi;
      for (int i = 0; i < 12; i++) send_pulse(hi_for(1'($urandom())), 10);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      m_nbits = 0;
      m_cur   = '0;
      m_fidx  = 0;
      tick();
      check_all_zero("midrst");
      check("midrst_no_fe", 64'(fe_count - fe0), 64'd0);
      check("midrst_no_valid", 64'(valid_hi - v0), 64'd0);
      send_pixel(24'($urandom()));
      end_frame(410);
      check("midrst_index", 64'(pixel_index), 64'd0);
      check_pixels("midrst");

      // Randomized frames with varying timing parameters.
      for (int f = 0; f < 5; f++) begin
         int np;
         threshold_cycles = 16'($urandom_range(30, 5));
         reset_cycles     = 16'($urandom_range(150, 60));
         np = int'($urandom_range(3, 1));
         fe0 = fe_count;
         for (int p = 0; p < np; p++) send_pixel(24'($urandom()));
         if ($urandom_range(2, 0) == 0)
            for (int b = 0; b < int'($urandom_range(23, 1)); b++)
               send_pulse(hi_for(1'($urandom())), int'($urandom_range(20, 5)));
         end_frame(int'(reset_cycles) + int'($urandom_range(20, 0)));
         check("rand_fe_count", 64'(fe_count - fe0), 64'd1);
         check("rand_partial", 64'(err_partial), 64'(exp_partial));
         check("rand_ovf", 64'(err_overflow), 64'd0);
         check_pixels("rand");
         pulse_clear();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
